// File: rtl/mem_stage_access_unit.sv
// MEM-stage load/store engine: issues one data-memory access per instruction and extends load data.
// Latency: 4 cycles in MEM when ready and response arrive first cycle (IDLE, REQ, WAIT_RSP, DONE).
// Backpressure: holds memStall while the request waits for ready/response; abandons after TIMEOUT_CYCLES.
module mem_stage_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readMemory_MEM,
    input  logic        writeMemory_MEM,
    input  logic [2:0]  funct3_MEM,
    input  logic [31:0] aluResult_MEM,
    input  logic [31:0] r2Data_MEM,
    output logic        memStall,
    output logic [31:0] loadData_MEM,
    output logic        loadValid,
    output logic        accessError,
    output logic        timeout,
    output logic        dmemReqValid,
    input  logic        dmemReqReady,
    output logic        dmemReqWrite,
    output logic [31:0] dmemReqAddr,
    output logic [31:0] dmemReqWdata,
    output logic [3:0]  dmemReqByteEn,
    input  logic        dmemRspValid,
    input  logic [31:0] dmemRspRdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cnt;
    logic [2:0]     funct3_q;
    logic [1:0]     off_q;
    logic           timed_out_q;

    logic           access;
    logic           is_load;
    logic           misaligned;
    logic           illegal;
    logic           bad;
    logic           expire;
    logic           start;
    logic           capture;
    logic [3:0]     byteen_nxt;
    logic [31:0]    wdata_nxt;
    logic [31:0]    shifted;
    logic [31:0]    ext_data;

    // Decode the instruction in MEM: access kind, alignment and funct3 legality.
    always_comb begin
        access     = readMemory_MEM | writeMemory_MEM;
        is_load    = readMemory_MEM;
        misaligned = 1'b0;
        case (funct3_MEM[1:0])
            2'b01:   misaligned = aluResult_MEM[0];
            2'b10:   misaligned = |aluResult_MEM[1:0];
            default: misaligned = 1'b0;
        endcase
        if (is_load)
            illegal = (funct3_MEM[1:0] == 2'b11) || (funct3_MEM[2:1] == 2'b11);
        else
            illegal = funct3_MEM[2] || (funct3_MEM[1:0] == 2'b11);
        bad = misaligned | illegal;
    end

    // Store lane enables and replicated write data; loads carry no lanes.
    always_comb begin
        byteen_nxt = 4'b0000;
        wdata_nxt  = 32'h0;
        if (!is_load) begin
            case (funct3_MEM[1:0])
                2'b00: begin
                    byteen_nxt = 4'b0001 << aluResult_MEM[1:0];
                    wdata_nxt  = {4{r2Data_MEM[7:0]}};
                end
                2'b01: begin
                    byteen_nxt = aluResult_MEM[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt  = {2{r2Data_MEM[15:0]}};
                end
                default: begin
                    byteen_nxt = 4'b1111;
                    wdata_nxt  = r2Data_MEM;
                end
            endcase
        end
    end

    // Align the returned word to the addressed byte and extend by access type.
    always_comb begin
        shifted = dmemRspRdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ext_data = {24'h0, shifted[7:0]};
            3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ext_data = {16'h0, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

    assign expire = (cnt == CW'(TIMEOUT_CYCLES - 1));

    // Next-state and per-state outputs; timeout takes priority over ready/response on the expiry cycle.
    always_comb begin
        state_nxt    = state;
        memStall     = 1'b0;
        dmemReqValid = 1'b0;
        accessError  = 1'b0;
        timeout      = 1'b0;
        loadValid    = 1'b0;
        start        = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (bad) begin
                        accessError = 1'b1;
                    end else begin
                        memStall  = 1'b1;
                        start     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                memStall = 1'b1;
                if (expire) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    dmemReqValid = 1'b1;
                    if (dmemReqReady)
                        state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                memStall = 1'b1;
                if (expire) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end else if (dmemRspValid) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                loadValid = !dmemReqWrite && !timed_out_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, latched request fields, timeout counter and load result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            funct3_q      <= 3'b000;
            off_q         <= 2'b00;
            timed_out_q   <= 1'b0;
            dmemReqWrite  <= 1'b0;
            dmemReqAddr   <= 32'h0;
            dmemReqWdata  <= 32'h0;
            dmemReqByteEn <= 4'b0000;
            loadData_MEM  <= 32'h0;
        end else begin
            state <= state_nxt;
            if (start) begin
                cnt           <= '0;
                timed_out_q   <= 1'b0;
                funct3_q      <= funct3_MEM;
                off_q         <= aluResult_MEM[1:0];
                dmemReqWrite  <= !is_load;
                dmemReqAddr   <= {aluResult_MEM[31:2], 2'b00};
                dmemReqWdata  <= wdata_nxt;
                dmemReqByteEn <= byteen_nxt;
            end else if (state == REQ || state == WAIT_RSP) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout) begin
                timed_out_q  <= 1'b1;
                loadData_MEM <= 32'h0;
            end else if (capture && !dmemReqWrite) begin
                loadData_MEM <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// Self-checking bench for mem_stage_access_unit: directed cases then randomized accesses.
// Expectations come from a transaction-level model (alignment rules, lane math, cycle budget).
// Memory side is driven by the bench with chosen ready/response delays per access.
module tb_mem_stage_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        readMemory_MEM;
    logic        writeMemory_MEM;
    logic [2:0]  funct3_MEM;
    logic [31:0] aluResult_MEM;
    logic [31:0] r2Data_MEM;
    logic        memStall;
    logic [31:0] loadData_MEM;
    logic        loadValid;
    logic        accessError;
    logic        timeout;
    logic        dmemReqValid;
    logic        dmemReqReady;
    logic        dmemReqWrite;
    logic [31:0] dmemReqAddr;
    logic [31:0] dmemReqWdata;
    logic [3:0]  dmemReqByteEn;
    logic        dmemRspValid;
    logic [31:0] dmemRspRdata;

    always #5 clk = ~clk;

    mem_stage_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .readMemory_MEM(readMemory_MEM), .writeMemory_MEM(writeMemory_MEM),
        .funct3_MEM(funct3_MEM), .aluResult_MEM(aluResult_MEM), .r2Data_MEM(r2Data_MEM),
        .memStall(memStall), .loadData_MEM(loadData_MEM), .loadValid(loadValid),
        .accessError(accessError), .timeout(timeout),
        .dmemReqValid(dmemReqValid), .dmemReqReady(dmemReqReady), .dmemReqWrite(dmemReqWrite),
        .dmemReqAddr(dmemReqAddr), .dmemReqWdata(dmemReqWdata), .dmemReqByteEn(dmemReqByteEn),
        .dmemRspValid(dmemRspValid), .dmemRspRdata(dmemRspRdata)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] last_ld = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: is the access rejected before any request?
    function automatic bit ref_bad(input bit rd, input int f3, input logic [31:0] addr);
        bit legal;
        int sz;
        if (rd) legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        else    legal = (f3 <= 2);
        if (!legal) return 1'b1;
        sz = 1 << (f3 % 4);
        return (addr % sz) != 0;
    endfunction

    // Reference: loaded value from the full word, byte offset and type.
    function automatic logic [31:0] ref_load(input int f3, input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] b;
        logic [31:0] h;
        sh = word / (32'd1 << (8 * (addr % 4)));
        b  = sh % 256;
        h  = sh % 65536;
        case (f3)
            0:       return (b >= 128) ? b - 32'd256 : b;
            4:       return b;
            1:       return (h >= 32768) ? h - 32'd65536 : h;
            5:       return h;
            default: return word;
        endcase
    endfunction

    // Reference: store byte lanes and lane-replicated data.
    task automatic ref_store(input int f3, input logic [31:0] addr, input logic [31:0] r2,
                             output logic [3:0] be, output logic [31:0] wd);
        if (f3 == 0) begin
            be = 4'(1 << (addr % 4));
            wd = (r2 % 256) * 32'h0101_0101;
        end else if (f3 == 1) begin
            be = ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
            wd = (r2 % 65536) * 32'h0001_0001;
        end else begin
            be = 4'b1111;
            wd = r2;
        end
    endtask

    // One MEM-stage instruction with given ready delay, response delay and read word.
    task automatic run_access(input bit rd, input bit wr, input int f3, input logic [31:0] addr,
                              input logic [31:0] r2, input int rdy_d, input int rsp_d,
                              input logic [31:0] rdata);
        bit          to;
        bit          in_req;
        int          t_all;
        int          last;
        logic [3:0]  be;
        logic [31:0] wd;
        @(negedge clk);
        readMemory_MEM  = rd;
        writeMemory_MEM = wr;
        funct3_MEM      = 3'(f3);
        aluResult_MEM   = addr;
        r2Data_MEM      = r2;
        dmemReqReady    = 1'b0;
        dmemRspValid    = 1'b0;
        #1;
        if (!(rd || wr)) begin
            chk("idle_stall", memStall, 0);
            chk("idle_err", accessError, 0);
            chk("idle_vld", dmemReqValid, 0);
            chk("idle_lv", loadValid, 0);
            return;
        end
        if (ref_bad(rd, f3, addr)) begin
            chk("err_pulse", accessError, 1);
            chk("err_stall", memStall, 0);
            chk("err_vld", dmemReqValid, 0);
            chk("err_ld", loadData_MEM, last_ld);
            return;
        end
        chk("start_stall", memStall, 1);
        chk("start_err", accessError, 0);
        ref_store(f3, addr, r2, be, wd);
        t_all = rdy_d + rsp_d + 2;
        to    = (t_all >= TO);
        last  = to ? TO : t_all;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            in_req = (k <= rdy_d + 1);
            if (in_req) begin
                dmemReqReady = (k == rdy_d + 1);
                dmemRspValid = 1'($urandom % 2);
                dmemRspRdata = $urandom;
            end else begin
                dmemReqReady = 1'b0;
                dmemRspValid = (k == t_all);
                dmemRspRdata = (k == t_all) ? rdata : $urandom;
            end
            #1;
            chk("busy_stall", memStall, 1);
            chk("busy_timeout", timeout, (to && k == TO) ? 1 : 0);
            chk("busy_vld", dmemReqValid, (in_req && k < TO) ? 1 : 0);
            chk("busy_lv", loadValid, 0);
            if (in_req && k < TO) begin
                chk("req_addr", dmemReqAddr, addr - (addr % 4));
                chk("req_write", dmemReqWrite, rd ? 0 : 1);
                chk("req_be", dmemReqByteEn, rd ? 4'b0000 : be);
                if (!rd) chk("req_wdata", dmemReqWdata, wd);
            end
        end
        @(negedge clk);
        dmemReqReady = 1'b0;
        dmemRspValid = 1'($urandom % 2);
        dmemRspRdata = $urandom;
        #1;
        if (to) last_ld = 32'h0;
        else if (rd) last_ld = ref_load(f3, addr, rdata);
        chk("done_stall", memStall, 0);
        chk("done_lv", loadValid, (rd && !to) ? 1 : 0);
        chk("done_ld", loadData_MEM, last_ld);
        chk("done_timeout", timeout, 0);
        chk("done_vld", dmemReqValid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, memStall, 0);
        chk({tag, "_ld"}, loadData_MEM, 0);
        chk({tag, "_lv"}, loadValid, 0);
        chk({tag, "_err"}, accessError, 0);
        chk({tag, "_to"}, timeout, 0);
        chk({tag, "_vld"}, dmemReqValid, 0);
        chk({tag, "_wr"}, dmemReqWrite, 0);
        chk({tag, "_addr"}, dmemReqAddr, 0);
        chk({tag, "_wd"}, dmemReqWdata, 0);
        chk({tag, "_be"}, dmemReqByteEn, 0);
    endtask

    initial begin
        reset           = 1'b1;
        readMemory_MEM  = 1'b0;
        writeMemory_MEM = 1'b0;
        funct3_MEM      = 3'b000;
        aluResult_MEM   = 32'h0;
        r2Data_MEM      = 32'h0;
        dmemReqReady    = 1'b0;
        dmemRspValid    = 1'b0;
        dmemRspRdata    = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        run_access(1, 0, 2, 32'h100, 32'h0, 0, 0, 32'hDEAD_BEEF);
        run_access(1, 0, 0, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF);
        run_access(1, 0, 4, 32'h103, 32'h0, 0, 0, 32'h80FF_FFFF);
        run_access(0, 1, 1, 32'h202, 32'h1234_ABCD, 0, 2, 32'h0);
        run_access(1, 0, 2, 32'h101, 32'h0, 0, 0, 32'h0);
        run_access(1, 0, 3, 32'h100, 32'h0, 0, 0, 32'h0);
        run_access(0, 1, 4, 32'h100, 32'h0, 0, 0, 32'h0);
        run_access(1, 1, 5, 32'h302, 32'h0, 1, 1, 32'h8765_4321);
        run_access(1, 0, 2, 32'h400, 32'h0, 19, 0, 32'h0);
        run_access(0, 1, 0, 32'h401, 32'hAA55, 3, 14, 32'h0);

        // Randomized accesses.
        for (int n = 0; n < 200; n++) begin
            bit          rd;
            bit          wr;
            int          f3;
            int          rdy_d;
            int          rsp_d;
            logic [31:0] addr;
            int          kind;
            kind  = $urandom_range(0, 9);
            rd    = (kind <= 5) || (kind == 8);
            wr    = (kind >= 6);
            f3    = $urandom_range(0, 7);
            addr  = $urandom;
            if ($urandom % 2 == 1) addr = addr - (addr % 4);
            rdy_d = ($urandom % 8 == 0) ? $urandom_range(0, 18) : $urandom_range(0, 3);
            rsp_d = ($urandom % 8 == 0) ? $urandom_range(0, 16) : $urandom_range(0, 3);
            run_access(rd, wr, f3, addr, $urandom, rdy_d, rsp_d, $urandom);
        end

        // Reset while waiting for a response, with the response arriving afterwards.
        @(negedge clk);
        readMemory_MEM = 1'b1; writeMemory_MEM = 1'b0; funct3_MEM = 3'b010;
        aluResult_MEM = 32'h40; dmemReqReady = 1'b0; dmemRspValid = 1'b0;
        @(negedge clk);
        dmemReqReady = 1'b1;
        #1;
        chk("rst_req_vld", dmemReqValid, 1);
        @(negedge clk);
        dmemReqReady = 1'b0;
        reset = 1'b1;
        readMemory_MEM = 1'b0;
        #1;
        chk("rst_wait_stall", memStall, 1);
        @(negedge clk);
        reset = 1'b0;
        dmemRspValid = 1'b1;
        dmemRspRdata = 32'hCAFE_F00D;
        #1;
        last_ld = 32'h0;
        check_all_zero("rst_abort");
        @(negedge clk);
        dmemRspValid = 1'b0;
        #1;
        chk("rst_late_lv", loadValid, 0);
        chk("rst_late_ld", loadData_MEM, last_ld);
        chk("rst_late_stall", memStall, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
